// File: rtl/mul16_seq.sv
// Sequential 16x16 -> 32 shift-add multiplier: one add-shift step per clock, 16 steps.
// Define MUL16_SEQ_SIGNED_EN for two's-complement operands (magnitude multiply plus sign fix-up).
module mul16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [16:0] sum;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [31:0] result;

`ifdef MUL16_SEQ_SIGNED_EN
  logic        sign_q, sign_d;

  // Operands are reduced to magnitudes; 0x8000 maps to itself, which is its correct magnitude.
  always_comb begin
    a_in   = a[15] ? (~a + 16'd1) : a;
    b_in   = b[15] ? (~b + 16'd1) : b;
    result = sign_q ? (~{acc_q, mplier_q} + 32'd1) : {acc_q, mplier_q};
  end
`else
  always_comb begin
    a_in   = a;
    b_in   = b;
    result = {acc_q, mplier_q};
  end
`endif

  always_comb begin
    sum = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : 17'd0);
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
`ifdef MUL16_SEQ_SIGNED_EN
    sign_d    = sign_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          mcand_d  = a_in;
          mplier_d = b_in;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
`ifdef MUL16_SEQ_SIGNED_EN
          sign_d   = a[15] ^ b[15];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == 5'd16) begin
          state_d   = DONE;
          done_d    = 1'b1;
          product_d = result;
        end else begin
          // Shift the 17-bit sum together with the multiplier so the carry lands in acc[15].
          acc_d    = sum[16:1];
          mplier_d = {sum[0], mplier_q[15:1]};
          cnt_d    = cnt_q + 5'd1;
          busy_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MUL16_SEQ_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MUL16_SEQ_SIGNED_EN
      sign_q    <= sign_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Directed bench for mul16_seq: latency, operand extremes, busy protection, back-to-back, reset abort.
module tb_mul16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int unsigned n_tests;
  int unsigned n_fail;

  mul16_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  // Start accepted at edge T; busy through edge T+16, done and product right after edge T+17.
  task automatic do_mul(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic [31:0] exp);
    a     = x;
    b     = y;
    start = 1'b1;
    edge1();
    start = 1'b0;
    check({tag, " busy_t0"}, {31'd0, busy}, 32'd1);
    repeat (16) edge1();
    check({tag, " busy_t16"}, {31'd0, busy}, 32'd1);
    check({tag, " done_t16"}, {31'd0, done}, 32'd0);
    edge1();
    check({tag, " done_t17"}, {31'd0, done}, 32'd1);
    check({tag, " busy_t17"}, {31'd0, busy}, 32'd0);
    check({tag, " product"}, product, exp);
  endtask

  initial begin
    logic [31:0] prev;
    logic        saw_done;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", product, 32'd0);
    edge1();
    edge1();
    rst = 1'b0;

    // Latency, with done dropping again and product holding.
    do_mul("lat3x5", 16'd3, 16'd5, 32'h0000000F);
    edge1();
    check("lat done_t18", {31'd0, done}, 32'd0);
    check("lat hold_t18", product, 32'h0000000F);
    edge1();

`ifdef MUL16_SEQ_SIGNED_EN
    do_mul("max", 16'hFFFF, 16'hFFFF, 32'h00000001);
    do_mul("neg2x3", 16'hFFFE, 16'h0003, 32'hFFFFFFFA);
    do_mul("min", 16'h8000, 16'h8000, 32'h40000000);
`else
    do_mul("max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    do_mul("fffex3", 16'hFFFE, 16'h0003, 32'h0002FFFA);
    do_mul("min", 16'h8000, 16'h8000, 32'h40000000);
`endif
    edge1();

    // Busy protection: start pulsed with new operands mid-RUN.
    a     = 16'h1234;
    b     = 16'h0010;
    start = 1'b1;
    edge1();
    start = 1'b0;
    repeat (5) edge1();
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    start = 1'b1;
    edge1();
    start = 1'b0;
    a     = 16'h0101;
    b     = 16'h0202;
    check("prot busy", {31'd0, busy}, 32'd1);
    repeat (10) edge1();
    check("prot done_t16", {31'd0, done}, 32'd0);
    edge1();
    check("prot done_t17", {31'd0, done}, 32'd1);
    check("prot product", product, 32'h00012340);

    // Back-to-back: start held in the DONE cycle.
    prev  = product;
    a     = 16'd7;
    b     = 16'd9;
    start = 1'b1;
    edge1();
    start = 1'b0;
    check("b2b busy_t0", {31'd0, busy}, 32'd1);
    check("b2b hold_t0", product, prev);
    repeat (16) edge1();
    check("b2b hold_t16", product, prev);
    check("b2b done_t16", {31'd0, done}, 32'd0);
    edge1();
    check("b2b done_t17", {31'd0, done}, 32'd1);
    check("b2b product", product, 32'h0000003F);
    edge1();

    // Reset mid-RUN aborts with no done pulse.
    a     = 16'd3;
    b     = 16'd5;
    start = 1'b1;
    edge1();
    start = 1'b0;
    repeat (8) edge1();
    #2;
    rst = 1'b1;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort product", product, 32'd0);
    edge1();
    #2;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      edge1();
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("abort no_done", {31'd0, saw_done}, 32'd0);
    check("abort product_hold", product, 32'd0);

    // First start after reset release is accepted immediately.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    do_mul("post_rst", 16'd100, 16'd200, 32'd20000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
